// File: rtl/register_file_4x32.sv
`default_nettype none
// ----------------------------------------------------------------------------
// register_file_4x32 : 4 x 32-bit scratch registers, one write port, one
//                      combinational read port sharing the write select.
// Revision: 1.0
// ----------------------------------------------------------------------------
module register_file_4x32 #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 4,
  parameter int SEL_WIDTH  = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  writeEn,
  input  logic [SEL_WIDTH-1:0]  writeSel,
  input  logic [DATA_WIDTH-1:0] writeData,
  output logic [DATA_WIDTH-1:0] readData1
);

  logic [DATA_WIDTH-1:0] r_regs [NUM_REGS];

  // One flop bank per register so each has its own enable decode.
  generate
    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
      always_ff @(posedge clk) begin
        if (rst) begin
          r_regs[g] <= '0;
        end else if (writeEn && (writeSel == SEL_WIDTH'(g))) begin
          r_regs[g] <= writeData;
        end
      end
    end
  endgenerate

  // No write bypass: the read shows the committed value only.
  assign readData1 = r_regs[writeSel];

endmodule
`default_nettype wire

// File: tb/tb_register_file_4x32.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_register_file_4x32 : queue-based scoreboard bench for register_file_4x32.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_register_file_4x32;

  logic        clk;
  logic        rst;
  logic        writeEn;
  logic [1:0]  writeSel;
  logic [31:0] writeData;
  logic [31:0] readData1;

  register_file_4x32 #(
    .DATA_WIDTH(32),
    .NUM_REGS  (4),
    .SEL_WIDTH (2)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .writeEn  (writeEn),
    .writeSel (writeSel),
    .writeData(writeData),
    .readData1(readData1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] exp_q [$];
  string       name_q [$];
  int          vectors = 0;
  int          miscompares = 0;
  bit          stim_done = 1'b0;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Push an expected read for the current select, then wait for the monitor.
  task automatic expect_rd(input logic [31:0] exp, input string name);
    int waited;
    exp_q.push_back(exp);
    name_q.push_back(name);
    waited = 0;
    while (exp_q.size() != 0 && waited < 100) begin
      #1;
      waited++;
    end
    if (exp_q.size() != 0) begin
      $display("FAIL %s: monitor timeout, no sample taken (required %h)", name, exp);
      miscompares++;
      exp_q.delete();
      name_q.delete();
    end
  endtask

  task automatic write_reg(input logic [1:0] sel, input logic [31:0] data);
    writeEn   = 1'b1;
    writeSel  = sel;
    writeData = data;
    tick();
    writeEn   = 1'b0;
  endtask

  // Monitor: samples readData1 whenever an expectation is pending.
  initial begin
    logic [31:0] e;
    string       n;
    while (!stim_done) begin
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        n = name_q.pop_front();
        vectors++;
        if (readData1 !== e) begin
          $display("FAIL %s: sel=%0d got %h required %h", n, writeSel, readData1, e);
          miscompares++;
        end
      end
      #1;
    end
  end

  initial begin
    logic [31:0] seq [6];
    seq[0] = 32'h00000000; seq[1] = 32'hFFFFFFFF; seq[2] = 32'h0F0F0F0F;
    seq[3] = 32'hFFFFFFFF; seq[4] = 32'h0F0F0F0F; seq[5] = 32'h00000000;

    rst = 1'b1; writeEn = 1'b0; writeSel = 2'd0; writeData = 32'h0;
    @(negedge clk);
    tick();
    rst = 1'b0;

    for (int s = 0; s < 4; s++) begin
      writeSel = 2'(s);
      expect_rd(32'h00000000, "reset_sweep");
    end

    // Basic write: old value visible before the committing edge.
    writeEn = 1'b1; writeSel = 2'd1; writeData = 32'hFFFFFFFF;
    expect_rd(32'h00000000, "no_bypass");
    tick();
    writeEn = 1'b0;
    expect_rd(32'hFFFFFFFF, "basic_write");

    // Back-to-back overwrites of register 2.
    writeEn = 1'b1; writeSel = 2'd2;
    for (int i = 0; i < 6; i++) begin
      writeData = seq[i];
      tick();
      expect_rd(seq[i], "overwrite");
    end
    writeEn = 1'b0;

    // Write disable holds the stored value.
    write_reg(2'd3, 32'h0F0F0F0F);
    expect_rd(32'h0F0F0F0F, "wr_reg3");
    writeData = 32'hFFFFFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_rd(32'h0F0F0F0F, "write_disable");
    end

    // Isolation from a clean state.
    rst = 1'b1; tick(); rst = 1'b0;
    write_reg(2'd0, 32'hA5A5A5A5);
    write_reg(2'd1, 32'h5A5A5A5A);
    writeSel = 2'd0; expect_rd(32'hA5A5A5A5, "iso_r0");
    writeSel = 2'd1; expect_rd(32'h5A5A5A5A, "iso_r1");
    writeSel = 2'd2; expect_rd(32'h00000000, "iso_r2");
    writeSel = 2'd3; expect_rd(32'h00000000, "iso_r3");

    // Reset beats a same-cycle write.
    rst = 1'b1; writeEn = 1'b1; writeSel = 2'd0; writeData = 32'hFFFFFFFF;
    tick();
    writeEn = 1'b0;
    for (int s = 0; s < 4; s++) begin
      writeSel = 2'(s);
      expect_rd(32'h00000000, "reset_priority");
    end

    // First write accepted on the first edge after reset deasserts.
    rst = 1'b0;
    write_reg(2'd2, 32'h12345678);
    expect_rd(32'h12345678, "post_reset_write");
    writeSel = 2'd1; expect_rd(32'h00000000, "post_reset_other");

    stim_done = 1'b1;
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
